// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR amplitude envelope advancing once per sample tick
module adsr_envelope #(
  parameter int WIDTH       = 16,
  parameter bit RETRIG_ZERO = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             sample_tick,
  input  logic             gate,
  input  logic [WIDTH-1:0] attack_step,
  input  logic [WIDTH-1:0] decay_step,
  input  logic [WIDTH-1:0] sustain_level,
  input  logic [WIDTH-1:0] release_step,
  output logic [WIDTH-1:0] level,
  output logic             active,
  output logic [2:0]       state,
  output logic             done
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;
  localparam logic [WIDTH-1:0] FULL = '1;
  state_t st, st_n;
  logic [WIDTH-1:0] lvl_n;
  logic [WIDTH:0] sum, diff;
  logic gate_prev, rise, fall, done_n;
  assign state = st;
  // next envelope step: gate edges win over the per-phase arithmetic, which saturates at 0 and full scale
  always_comb begin
    sum = {1'b0, level} + {1'b0, attack_step};
    diff = {1'b0, level} - {1'b0, decay_step};
    rise = gate & ~gate_prev;
    fall = ~gate & gate_prev;
    st_n = st;
    lvl_n = level;
    done_n = 1'b0;
    if (rise && (st == IDLE || st == RELEASE)) begin
      st_n = ATTACK;
      lvl_n = RETRIG_ZERO ? '0 : level;
    end else if (fall && (st == ATTACK || st == DECAY || st == SUSTAIN)) begin
      st_n = RELEASE;
    end else begin
      case (st)
        ATTACK: begin
          st_n = (sum >= {1'b0, FULL}) ? DECAY : ATTACK;
          lvl_n = (sum >= {1'b0, FULL}) ? FULL : sum[WIDTH-1:0];
        end
        DECAY: begin
          st_n = (diff[WIDTH] || diff[WIDTH-1:0] <= sustain_level) ? SUSTAIN : DECAY;
          lvl_n = (diff[WIDTH] || diff[WIDTH-1:0] <= sustain_level) ? sustain_level : diff[WIDTH-1:0];
        end
        SUSTAIN: lvl_n = sustain_level;
        RELEASE: begin
          st_n = (level <= release_step) ? IDLE : RELEASE;
          lvl_n = (level <= release_step) ? '0 : level - release_step;
          done_n = (level <= release_step);
        end
        default: begin
          st_n = IDLE;
          lvl_n = '0;
        end
      endcase
    end
  end
  // envelope registers advance only on ticks; done is refreshed every Clk so it lasts one cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st <= IDLE;
      level <= '0;
      active <= 1'b0;
      done <= 1'b0;
      gate_prev <= 1'b0;
    end else begin
      done <= sample_tick & done_n;
      if (sample_tick) begin
        st <= st_n;
        level <= lvl_n;
        active <= (st_n != IDLE);
        gate_prev <= gate;
      end
    end
  end
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: random and directed checks of both retrigger modes against an integer reference model
module tb_adsr_envelope;
  logic Clk = 1'b0, Reset = 1'b1, sample_tick = 1'b0, gate = 1'b0;
  logic [15:0] attack_step = '0, decay_step = '0, sustain_level = '0, release_step = '0;
  logic [15:0] lv0, lv1;
  logic [2:0] st0, st1;
  logic act0, act1, dn0, dn1;
  int n_chk = 0, n_pass = 0;
  int m_lvl[2], m_st[2], m_gp[2], m_done[2];
  localparam int FULL = 65535;
  always #5 Clk = ~Clk;
  adsr_envelope #(.WIDTH(16), .RETRIG_ZERO(1'b0)) u0 (
    .Clk(Clk), .Reset(Reset), .sample_tick(sample_tick), .gate(gate),
    .attack_step(attack_step), .decay_step(decay_step), .sustain_level(sustain_level),
    .release_step(release_step), .level(lv0), .active(act0), .state(st0), .done(dn0));
  adsr_envelope #(.WIDTH(16), .RETRIG_ZERO(1'b1)) u1 (
    .Clk(Clk), .Reset(Reset), .sample_tick(sample_tick), .gate(gate),
    .attack_step(attack_step), .decay_step(decay_step), .sustain_level(sustain_level),
    .release_step(release_step), .level(lv1), .active(act1), .state(st1), .done(dn1));
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask
  // states: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release; r=1 restarts attack at zero
  function automatic void model_step();
    for (int r = 0; r < 2; r++) begin
      if (Reset) begin
        m_lvl[r] = 0; m_st[r] = 0; m_gp[r] = 0; m_done[r] = 0;
      end else begin
        m_done[r] = 0;
        if (sample_tick) begin
          bit rise, fall;
          int a, d, s, rl;
          rise = gate && !m_gp[r];
          fall = !gate && m_gp[r];
          m_gp[r] = gate;
          a = attack_step; d = decay_step; s = sustain_level; rl = release_step;
          if (rise && (m_st[r] == 0 || m_st[r] == 4)) begin
            m_st[r] = 1;
            if (r == 1) m_lvl[r] = 0;
          end else if (fall && m_st[r] >= 1 && m_st[r] <= 3) m_st[r] = 4;
          else if (m_st[r] == 1) begin
            if (m_lvl[r] + a >= FULL) begin m_lvl[r] = FULL; m_st[r] = 2; end
            else m_lvl[r] = m_lvl[r] + a;
          end else if (m_st[r] == 2) begin
            if (m_lvl[r] - d <= s) begin m_lvl[r] = s; m_st[r] = 3; end
            else m_lvl[r] = m_lvl[r] - d;
          end else if (m_st[r] == 3) m_lvl[r] = s;
          else if (m_st[r] == 4) begin
            if (m_lvl[r] <= rl) begin m_lvl[r] = 0; m_st[r] = 0; m_done[r] = 1; end
            else m_lvl[r] = m_lvl[r] - rl;
          end else m_lvl[r] = 0;
        end
      end
    end
  endfunction
  task automatic clk_cycle(input logic t);
    sample_tick = t;
    model_step();
    @(posedge Clk);
    #1;
    chk("lvl0", lv0, m_lvl[0]); chk("st0", st0, m_st[0]);
    chk("act0", act0, m_st[0] != 0); chk("done0", dn0, m_done[0]);
    chk("lvl1", lv1, m_lvl[1]); chk("st1", st1, m_st[1]);
    chk("act1", act1, m_st[1] != 0); chk("done1", dn1, m_done[1]);
  endtask
  task automatic tick();
    clk_cycle(1'b0);
    clk_cycle(1'b1);
  endtask
  task automatic tk_exp(input string tag, input int lvl, input int st);
    tick();
    chk({tag, "_lvl"}, lv0, lvl);
    chk({tag, "_st"}, st0, st);
  endtask
  function automatic logic [15:0] rstep();
    case ($urandom_range(0, 3))
      0: return 16'h0;
      1: return 16'($urandom_range(1, 255));
      2: return 16'($urandom_range(256, 16383));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction
  initial begin
    m_lvl = '{0, 0}; m_st = '{0, 0}; m_gp = '{0, 0}; m_done = '{0, 0};
    attack_step = 16'h4000; decay_step = 16'h1000; sustain_level = 16'hC000; release_step = 16'h8000;
    gate = 1'b1;
    clk_cycle(1'b0);
    clk_cycle(1'b1);
    chk("rst_lvl", lv0, 0); chk("rst_st", st0, 0); chk("rst_act", act0, 0); chk("rst_done", dn0, 0);
    Reset = 1'b0;
    tk_exp("first", 0, 1);
    chk("first_act", act0, 1);
    tk_exp("att1", 16'h4000, 1); tk_exp("att2", 16'h8000, 1);
    tk_exp("att3", 16'hC000, 1); tk_exp("att4", 16'hFFFF, 2);
    tk_exp("dec1", 16'hEFFF, 2); tk_exp("dec2", 16'hDFFF, 2);
    tk_exp("dec3", 16'hCFFF, 2); tk_exp("dec4", 16'hC000, 3);
    gate = 1'b0;
    tk_exp("rel1", 16'hC000, 4); tk_exp("rel2", 16'h4000, 4); tk_exp("rel3", 0, 0);
    chk("rel_done", dn0, 1); chk("rel_act", act0, 0);
    clk_cycle(1'b0);
    chk("done_pulse", dn0, 0);
    gate = 1'b1;
    tk_exp("er0", 0, 1); tk_exp("er1", 16'h4000, 1); tk_exp("er2", 16'h8000, 1);
    gate = 1'b0;
    tk_exp("er_rel", 16'h8000, 4); tk_exp("er_idle", 0, 0);
    gate = 1'b1;
    repeat (9) tick();
    gate = 1'b0;
    tick(); tick();
    chk("rt_pre", lv0, 16'h4000);
    gate = 1'b1;
    tk_exp("rt0", 16'h4000, 1);
    chk("rt1_lvl", lv1, 0); chk("rt1_st", st1, 1);
    tk_exp("rt0_next", 16'h8000, 1);
    gate = 1'b0;
    repeat (4) tick();
    gate = 1'b1;
    repeat (9) tick();
    chk("sus_st", st0, 3);
    sustain_level = 16'h2000;
    tk_exp("sus_live", 16'h2000, 3);
    sustain_level = 16'hC000;
    gate = 1'b0;
    repeat (4) tick();
    gate = 1'b1;
    repeat (6) tick();
    chk("pre_rst_st", st0, 2);
    Reset = 1'b1;
    clk_cycle(1'b1);
    chk("mid_rst_lvl", lv0, 0); chk("mid_rst_st", st0, 0);
    chk("mid_rst_act", act0, 0); chk("mid_rst_done", dn0, 0);
    Reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      if ($urandom_range(0, 49) == 0) attack_step = rstep();
      if ($urandom_range(0, 49) == 0) decay_step = rstep();
      if ($urandom_range(0, 49) == 0) release_step = rstep();
      if ($urandom_range(0, 79) == 0) sustain_level = 16'($urandom_range(0, 65535));
      Reset = ($urandom_range(0, 299) == 0);
      clk_cycle(1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Per-voice ADSR amplitude envelope generator, one stage upstream of the voice's conditional 16x16 gain multiplier.
- `level` drives the multiplier's datab; `active` drives its condition input.
- Advances once per audio `sample_tick`, using run-time attack, decay and release step sizes and a sustain level.

Parameters:
- WIDTH, 16, envelope level and step width; the full-scale level is 2^WIDTH-1.
- RETRIG_ZERO, 0: 1 = a retrigger from RELEASE restarts the attack at 0; 0 = the attack continues from the current level.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- sample_tick  in  1  one-Clk pulse per audio sample; all envelope updates occur only on tick cycles
- gate  in  1  note-on level (1 = key held)
- attack_step  in  WIDTH  added to level per tick in ATTACK
- decay_step  in  WIDTH  subtracted from level per tick in DECAY
- sustain_level  in  WIDTH  hold level in SUSTAIN
- release_step  in  WIDTH  subtracted from level per tick in RELEASE
- level  out  WIDTH  current envelope value (registered)
- active  out  1  1 when state != IDLE (registered)
- state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- done  out  1  one-Clk pulse on the RELEASE->IDLE transition

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, level=0, active=0, done=0, gate_prev=0.
  - A tick in the same cycle as Reset is ignored.
  - Reset mid-envelope aborts immediately; no done pulse is issued.
- Timing:
  - Registers change only on the Clk edge where sample_tick=1, except `done`.
  - All outputs are valid the cycle after the tick, giving 1-Clk latency.
  - `done` is high only for the Clk following the terminating tick.
- Gate handling:
  - gate is sampled only on ticks.
  - gate_prev holds the gate value sampled at the previous tick.
  - rise = gate & ~gate_prev; fall = ~gate & gate_prev.
- Edge rules (edges take priority over arithmetic on that tick; level is unchanged unless stated):
  - rise in IDLE or RELEASE -> ATTACK. Level becomes 0 if RETRIG_ZERO=1.
  - fall in ATTACK, DECAY or SUSTAIN -> RELEASE.
  - A rise in ATTACK, DECAY or SUSTAIN is impossible without an intervening fall.
  - A gate pulse shorter than one tick period is not seen.
- ATTACK (no edge): sum = level + attack_step, computed WIDTH+1 wide.
  - If sum >= 2^WIDTH-1: level = 2^WIDTH-1 and state -> DECAY.
  - Otherwise level = sum.
- DECAY:
  - If level - decay_step <= sustain_level (including borrow/underflow): level = sustain_level and state -> SUSTAIN.
  - Otherwise level = level - decay_step.
  - If sustain_level = full scale, SUSTAIN is reached on the first decay tick.
- SUSTAIN: level = sustain_level every tick, so it tracks live changes. Exits only on fall.
- RELEASE:
  - If level <= release_step: level = 0, state -> IDLE, done pulses.
  - Otherwise level = level - release_step.
- IDLE: level stays 0. Exits only on rise.
- Zero steps:
  - A step of 0 stalls the phase indefinitely, except that a gate edge still applies.
  - Exception: decay_step=0 with level already equal to sustain_level moves to SUSTAIN.
- Step inputs are sampled on each tick; changing them mid-phase takes effect at the next tick.
- Saturation: no wrap-around is ever visible on `level`; arithmetic saturates at 0 and at full scale.

Test Plan:
- Reset with gate=1 held, then first tick: level stays 0, state goes IDLE->ATTACK, active=1 on the next Clk.
- Full ADSR cycle:
  - Setup: attack_step=0x4000, decay_step=0x1000, sustain=0xC000, release_step=0x8000.
  - Attack ticks give level 0x4000, 0x8000, 0xC000, then 0xFFFF with state DECAY.
  - Decay ticks give 0xEFFF, 0xDFFF, 0xCFFF, then 0xC000 with state SUSTAIN.
  - Drop gate: the next tick gives RELEASE with level 0xC000; following ticks give 0x4000, then 0x0000 with state IDLE, done=1 for one Clk and active=0.
- Early release: gate falls while level is 0x8000 in ATTACK -> RELEASE at 0x8000; with release_step=0x8000 the next tick gives 0 and IDLE.
- Retrigger in RELEASE at level 0x4000:
  - RETRIG_ZERO=0: ATTACK continues from 0x4000, next tick 0x8000.
  - RETRIG_ZERO=1: level is 0 on the retrigger tick.
- Live sustain: in SUSTAIN, change sustain_level from 0xC000 to 0x2000 -> level is 0x2000 after the next tick.
- Reset asserted mid-DECAY coincident with a tick: the next Clk shows level=0, IDLE, active=0, done=0.
